// File: rtl/npc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the NPC core, with sticky halt/error.
// Optional performance counters (cycle_cnt, retire_cnt) are enabled by defining NPC_CTRL_PERF_EN.

`ifndef INST_NUM_WIDTH
`define INST_NUM_WIDTH 6
`endif

module npc_ctrl #(
    parameter int TIMEOUT   = 255,
    parameter int CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [`INST_NUM_WIDTH-1:0] inst_num,
    input  logic                       imem_valid,
    input  logic                       dmem_ready,
    output logic                       imem_req,
    output logic                       inst_we,
    output logic                       dmem_req,
    output logic                       reg_we,
    output logic                       pc_we,
    output logic                       halt,
    output logic                       error,
    output logic [2:0]                 state_o
`ifdef NPC_CTRL_PERF_EN
    ,
    output logic [63:0]                cycle_cnt,
    output logic [63:0]                retire_cnt
`endif
);

    localparam logic [`INST_NUM_WIDTH-1:0] INST_INV    = `INST_NUM_WIDTH'(0);
    localparam logic [`INST_NUM_WIDTH-1:0] INST_SW     = `INST_NUM_WIDTH'(2);
    localparam logic [`INST_NUM_WIDTH-1:0] INST_BEQ    = `INST_NUM_WIDTH'(3);
    localparam logic [`INST_NUM_WIDTH-1:0] INST_EBREAK = `INST_NUM_WIDTH'(4);
    localparam logic [CNT_WIDTH-1:0]       CNT_LIMIT   = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0]       CNT_MAX     = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 error_q;
    logic                 error_next;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 timed_out;

    assign timed_out = (wait_cnt == CNT_LIMIT);

    always_comb begin
        state_next = state;
        error_next = error_q;
        case (state)
            IDLE:   state_next = FETCH;
            FETCH: begin
                // A handshake landing on the timeout cycle still succeeds.
                if (imem_valid) begin
                    state_next = DECODE;
                end else if (timed_out) begin
                    state_next = HALT;
                    error_next = 1'b1;
                end
            end
            DECODE: state_next = EXEC;
            EXEC: begin
                if (inst_num == INST_INV) begin
                    state_next = HALT;
                    error_next = 1'b1;
                end else if (inst_num == INST_EBREAK) begin
                    state_next = HALT;
                end else if (inst_num == INST_SW) begin
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                if (dmem_ready) begin
                    state_next = WB;
                end else if (timed_out) begin
                    state_next = HALT;
                    error_next = 1'b1;
                end
            end
            WB:     state_next = FETCH;
            HALT:   state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            error_q  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state   <= state_next;
            error_q <= error_next;
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if ((state == FETCH || state == MEM) && wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Outputs are masked by rst so a reset landing mid-handshake emits no strobe that cycle.
    always_comb begin
        imem_req = 1'b0;
        inst_we  = 1'b0;
        dmem_req = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        halt     = 1'b0;
        error    = 1'b0;
        if (rst) begin
            imem_req = (state == FETCH);
            inst_we  = (state == FETCH) && imem_valid;
            dmem_req = (state == MEM);
            pc_we    = (state == WB);
            reg_we   = (state == WB) && (inst_num != INST_SW) && (inst_num != INST_BEQ);
            halt     = (state == HALT);
            error    = error_q;
        end
    end

    assign state_o = state;

`ifdef NPC_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (state != HALT) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            if (pc_we || (state == EXEC && inst_num == INST_EBREAK)) begin
                retire_cnt <= retire_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_npc_ctrl.sv
// Directed, table-driven bench for npc_ctrl; a second instance with TIMEOUT=4 covers the timeout path.

`ifndef INST_NUM_WIDTH
`define INST_NUM_WIDTH 6
`endif

module tb_npc_ctrl;

    localparam int W = `INST_NUM_WIDTH;
    localparam logic [W-1:0] I_INV = W'(0);
    localparam logic [W-1:0] I_ADD = W'(1);
    localparam logic [W-1:0] I_SW  = W'(2);
    localparam logic [W-1:0] I_BEQ = W'(3);
    localparam logic [W-1:0] I_EBK = W'(4);

    typedef struct {
        logic         r;
        logic         iv;
        logic         dr;
        logic [W-1:0] inum;
        logic [9:0]   exp;
        string        name;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b0, imem_valid = 1'b0, dmem_ready = 1'b0;
    logic [W-1:0] inst_num = I_ADD;
    logic         imem_req, inst_we, dmem_req, reg_we, pc_we, halt, error;
    logic [2:0]   state_o;

    logic         rst2 = 1'b0, iv2 = 1'b0;
    logic         imem_req2, inst_we2, dmem_req2, reg_we2, pc_we2, halt2, error2;
    logic [2:0]   state2;

`ifdef NPC_CTRL_PERF_EN
    logic [63:0] cycle_cnt, retire_cnt, cycle_cnt2, retire_cnt2;
`endif

    npc_ctrl dut (
        .clk(clk), .rst(rst), .inst_num(inst_num), .imem_valid(imem_valid),
        .dmem_ready(dmem_ready), .imem_req(imem_req), .inst_we(inst_we),
        .dmem_req(dmem_req), .reg_we(reg_we), .pc_we(pc_we), .halt(halt),
        .error(error), .state_o(state_o)
`ifdef NPC_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
`endif
    );

    npc_ctrl #(.TIMEOUT(4), .CNT_WIDTH(8)) dut_to (
        .clk(clk), .rst(rst2), .inst_num(I_ADD), .imem_valid(iv2),
        .dmem_ready(1'b0), .imem_req(imem_req2), .inst_we(inst_we2),
        .dmem_req(dmem_req2), .reg_we(reg_we2), .pc_we(pc_we2), .halt(halt2),
        .error(error2), .state_o(state2)
`ifdef NPC_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt2), .retire_cnt(retire_cnt2)
`endif
    );

    int total = 0;
    int bad   = 0;
    vec_t va[$];
    vec_t vb[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // o = {imem_req, inst_we, dmem_req, reg_we, pc_we, halt, error}
    task automatic add(input bit to_b, input logic r, input logic iv, input logic dr,
                       input logic [W-1:0] inum, input logic [2:0] st,
                       input logic [6:0] o, input string nm);
        vec_t v;
        v.r = r; v.iv = iv; v.dr = dr; v.inum = inum; v.exp = {st, o}; v.name = nm;
        if (to_b) vb.push_back(v);
        else va.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        rst = v.r; imem_valid = v.iv; dmem_ready = v.dr; inst_num = v.inum;
        #1;
        check(v.name, {54'd0, state_o, imem_req, inst_we, dmem_req, reg_we, pc_we, halt, error},
              {54'd0, v.exp});
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset, addi, beq (one fetch wait), sw (5 stall cycles), ebreak.
        add(0, 0, 1, 1, I_ADD, 3'd0, 7'b0000000, "rst_hold_a");
        add(0, 0, 1, 1, I_ADD, 3'd0, 7'b0000000, "rst_hold_b");
        add(0, 1, 0, 0, I_ADD, 3'd0, 7'b0000000, "idle");
        add(0, 1, 1, 0, I_ADD, 3'd1, 7'b1100000, "addi_fetch");
        add(0, 1, 0, 0, I_ADD, 3'd2, 7'b0000000, "addi_decode");
        add(0, 1, 0, 0, I_ADD, 3'd3, 7'b0000000, "addi_exec");
        add(0, 1, 0, 0, I_ADD, 3'd5, 7'b0001100, "addi_wb");
        add(0, 1, 0, 0, I_BEQ, 3'd1, 7'b1000000, "beq_fetch_wait");
        add(0, 1, 1, 0, I_BEQ, 3'd1, 7'b1100000, "beq_fetch");
        add(0, 1, 0, 0, I_BEQ, 3'd2, 7'b0000000, "beq_decode");
        add(0, 1, 0, 0, I_BEQ, 3'd3, 7'b0000000, "beq_exec");
        add(0, 1, 0, 0, I_BEQ, 3'd5, 7'b0000100, "beq_wb");
        add(0, 1, 1, 0, I_SW,  3'd1, 7'b1100000, "sw_fetch");
        add(0, 1, 0, 0, I_SW,  3'd2, 7'b0000000, "sw_decode");
        add(0, 1, 0, 0, I_SW,  3'd3, 7'b0000000, "sw_exec");
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, I_SW, 3'd4, 7'b0010000, "sw_mem_stall");
        add(0, 1, 0, 1, I_SW,  3'd4, 7'b0010000, "sw_mem_ready");
        add(0, 1, 0, 0, I_SW,  3'd5, 7'b0000100, "sw_wb");
        add(0, 1, 1, 0, I_EBK, 3'd1, 7'b1100000, "ebreak_fetch");
        add(0, 1, 0, 0, I_EBK, 3'd2, 7'b0000000, "ebreak_decode");
        add(0, 1, 0, 0, I_EBK, 3'd3, 7'b0000000, "ebreak_exec");
        add(0, 1, 0, 0, I_EBK, 3'd6, 7'b0000010, "ebreak_halt");
        // Reset out of HALT, inv, then reset during a MEM handshake, then three addi.
        add(1, 0, 1, 0, I_INV, 3'd6, 7'b0000000, "rst_in_halt");
        add(1, 0, 0, 0, I_INV, 3'd0, 7'b0000000, "rst_idle");
        add(1, 1, 0, 0, I_INV, 3'd0, 7'b0000000, "inv_idle");
        add(1, 1, 1, 0, I_INV, 3'd1, 7'b1100000, "inv_fetch");
        add(1, 1, 0, 0, I_INV, 3'd2, 7'b0000000, "inv_decode");
        add(1, 1, 0, 0, I_INV, 3'd3, 7'b0000000, "inv_exec");
        add(1, 1, 0, 0, I_INV, 3'd6, 7'b0000011, "inv_halt");
        add(1, 1, 1, 1, I_INV, 3'd6, 7'b0000011, "inv_halt_hold");
        add(1, 0, 0, 0, I_SW,  3'd6, 7'b0000000, "rst_again");
        add(1, 1, 0, 0, I_SW,  3'd0, 7'b0000000, "sw2_idle");
        add(1, 1, 1, 0, I_SW,  3'd1, 7'b1100000, "sw2_fetch");
        add(1, 1, 0, 0, I_SW,  3'd2, 7'b0000000, "sw2_decode");
        add(1, 1, 0, 0, I_SW,  3'd3, 7'b0000000, "sw2_exec");
        add(1, 1, 0, 0, I_SW,  3'd4, 7'b0010000, "sw2_mem");
        add(1, 0, 0, 1, I_SW,  3'd4, 7'b0000000, "rst_in_mem");
        add(1, 1, 0, 0, I_SW,  3'd0, 7'b0000000, "after_mem_rst");
        for (int k = 0; k < 3; k++) begin
            add(1, 1, 1, 0, I_ADD, 3'd1, 7'b1100000, "addi3_fetch");
            add(1, 1, 0, 0, I_ADD, 3'd2, 7'b0000000, "addi3_decode");
            add(1, 1, 0, 0, I_ADD, 3'd3, 7'b0000000, "addi3_exec");
            add(1, 1, 0, 0, I_ADD, 3'd5, 7'b0001100, "addi3_wb");
        end

        step();
`ifdef NPC_CTRL_PERF_EN
        check("perf_reset_cycle", cycle_cnt, 64'd0);
        check("perf_reset_retire", retire_cnt, 64'd0);
`endif
        foreach (va[i]) apply(va[i]);

`ifdef NPC_CTRL_PERF_EN
        check("perf_retire_halt", retire_cnt, 64'd4);
`endif
        // HALT must hold for 100 cycles regardless of imem_valid activity.
        for (int c = 0; c < 100; c++) begin
            imem_valid = c[0];
            dmem_ready = ~c[0];
            #1;
            check("halt_hold", {57'd0, state_o, imem_req, inst_we, dmem_req, pc_we},
                  {57'd6, 4'b0000});
            if (!halt || error) check("halt_flags", {62'd0, halt, error}, 64'd2);
            step();
        end

        foreach (vb[i]) apply(vb[i]);
`ifdef NPC_CTRL_PERF_EN
        check("perf_retire_3addi", retire_cnt, 64'd3);
`endif

        // Timeout instance: imem_valid stuck low.
        step();
        rst2 = 1'b1;
        step();
        check("to_fetch", {61'd0, state2}, 64'd1);
        n = 0;
        while (state2 == 3'd1 && n < 20) begin
            step();
            n++;
        end
        check("to_fetch_cycles", n, 64'd5);
        check("to_halt", {61'd0, state2, halt2, error2}, {61'd6, 2'b11});

        // Handshake on the timeout cycle wins.
        rst2 = 1'b0;
        step();
        rst2 = 1'b1;
        step();
        for (int c = 0; c < 4; c++) step();
        check("to_edge_still_fetch", {61'd0, state2}, 64'd1);
        iv2 = 1'b1;
        #1;
        check("to_edge_inst_we", {63'd0, inst_we2}, 64'd1);
        step();
        iv2 = 1'b0;
        check("to_edge_decode", {61'd0, state2, halt2, error2}, {61'd2, 2'b00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/npc_ctrl.md
Name: npc_ctrl

Overview:
- Multi-cycle sequencer for the NPC core. Drives the fetch -> decode -> execute -> memory/writeback loop around the combinational decoder.
- Issues instruction-memory and data-memory handshakes and latches the fetched instruction for the decoder.
- Generates register-file and PC write strobes.
- Halts the core on ebreak, on an invalid opcode, or on a memory timeout.

Parameters:
- TIMEOUT, 255, maximum wait cycles on any memory handshake before error halt.
- CNT_WIDTH, 8, width of the wait counter; must satisfy 2^CNT_WIDTH > TIMEOUT.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- inst_num  in  `INST_NUM_WIDTH  decoded instruction number from decoder
- imem_valid  in  1  instruction memory returns data this cycle
- dmem_ready  in  1  data memory accepted store this cycle
- imem_req  out  1  instruction fetch request
- inst_we  out  1  latch imem data into instruction register
- dmem_req  out  1  store request
- reg_we  out  1  register-file write strobe
- pc_we  out  1  PC update strobe
- halt  out  1  core stopped (sticky)
- error  out  1  halt cause is invalid instruction or timeout (sticky)
- state_o  out  3  current state, for trace/debug

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Reset: on a clk edge with rst=0, state=IDLE, wait counter=0, halt=0, error=0. All strobes are 0 during reset.
  - Reset mid-operation aborts any handshake with no write strobe in the reset cycle.
- Outputs are Moore outputs decoded from the registered state:
  - imem_req=1 in FETCH.
  - dmem_req=1 in MEM.
  - halt=1 in HALT.
  - state_o is the state encoding.
- IDLE -> FETCH unconditionally, 1 cycle after reset release.
- FETCH:
  - imem_req is held until imem_valid=1.
  - In the imem_valid cycle, inst_we=1 (combinational with imem_valid & FETCH), then go to DECODE.
  - Otherwise the wait counter increments.
  - If the counter reaches TIMEOUT with imem_valid still 0, go to HALT with error=1.
- DECODE: 1 cycle; the decoder output is stable from the latched instruction. Go to EXEC.
- EXEC: 1 cycle; branch decision from the execute unit.
  - inst_num=`inv -> HALT with error=1.
  - inst_num=`ebreak -> HALT with error=0.
  - inst_num=`sw -> MEM.
  - else -> WB.
- MEM:
  - dmem_req is held until dmem_ready=1, then go to WB.
  - Same timeout rule as FETCH.
- WB: 1 cycle. pc_we=1. reg_we=1 unless inst_num is `sw or `beq. Go to FETCH.
- Wait counter:
  - Clears on every state change.
  - Saturates and never wraps.
  - A handshake completing in the same cycle the counter hits TIMEOUT counts as success (valid/ready wins).
- HALT is absorbing: only reset exits it. All strobes stay 0. halt and error hold.
- Per-instruction latency is 4 cycles plus memory wait cycles (FETCH, DECODE, EXEC, WB), with MEM adding at least 1 for stores.
- Exactly one pc_we pulse per retired instruction. No pc_we or reg_we for ebreak/inv.

Optional Feature:
- Macro: NPC_CTRL_PERF_EN.
- When defined, adds output ports cycle_cnt[63:0] and retire_cnt[63:0], both reset to 0.
  - cycle_cnt increments every cycle while not in HALT.
  - retire_cnt increments on each pc_we pulse, and on the EXEC->HALT transition for ebreak.
  - Both freeze in HALT and wrap modulo 2^64.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset/IDLE: hold rst=0 for 3 cycles, then rst=1 -> all outputs 0 during reset; state_o=0 then 1; imem_req=1 on the 2nd cycle after release.
- addi, imem_valid immediate: imem_valid=1 on the first FETCH cycle, inst_num=`addi -> inst_we pulse, then DECODE, EXEC; WB with reg_we=1 and pc_we=1 exactly 3 cycles after inst_we; FETCH again next cycle.
- sw with 5-cycle dmem stall: dmem_ready rises on the 6th MEM cycle -> dmem_req high 6 cycles, then WB with pc_we=1 and reg_we=0.
- beq: inst_num=`beq -> WB with pc_we=1 and reg_we=0.
- ebreak and inv:
  - inst_num=`ebreak -> HALT with halt=1, error=0; no pc_we; stays halted 100 cycles despite imem_valid toggling.
  - Separate run with `inv -> halt=1, error=1.
- Timeout plus mid-run reset:
  - imem_valid stuck 0 with TIMEOUT=4 -> HALT with error=1 after 4 wait cycles.
  - Separately, assert rst=0 in MEM -> next state IDLE, dmem_req=0, no reg_we/pc_we.
  - With NPC_CTRL_PERF_EN, retire_cnt=0 after reset and 3 after three addi.
